// File: rtl/prco_seq_ctrl.sv
// prco_seq_ctrl: multi-cycle instruction sequencer for the prco core.
// Steps fetch/decode/exec/resp/mem/wb, drives PC control and stage enables,
// and provides halt/resume, RAM-timeout error and retired-instruction count.
module prco_seq_ctrl #(
    parameter int unsigned P_RAM_TIMEOUT = 15,
    parameter int unsigned P_CNT_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic               i_halt_req,
    input  logic               i_resume,
    input  logic               i_clr_err,
    input  logic               i_fetch_ack,
    input  logic               i_ram_ack,
    input  logic               i_alu_ce_reg,
    input  logic               i_alu_ce_ram,
    input  logic               i_alu_branch,
    output logic               q_ce_fetch,
    output logic               q_ce_dec,
    output logic               q_ce_alu,
    output logic               q_ce_wb,
    output logic               q_pc_load,
    output logic               q_pc_inc,
    output logic               q_halted,
    output logic               q_err,
    output logic [2:0]         q_state,
    output logic [P_CNT_W-1:0] q_instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_RESP   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           tmo_q, tmo_d;
    logic                 halt_pending_q, halt_pending_d;
    logic                 err_q, err_d;
    logic [P_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 ce_fetch_q, ce_fetch_d;
    logic                 ce_dec_q, ce_dec_d;
    logic                 ce_alu_q, ce_alu_d;
    logic                 ce_wb_q, ce_wb_d;
    logic                 pc_load_q, pc_load_d;
    logic                 pc_inc_q, pc_inc_d;
    logic                 halted_q, halted_d;
    logic                 retire;
    state_e               boundary;

    // State register and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            tmo_q          <= '0;
            halt_pending_q <= 1'b0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
            ce_fetch_q     <= 1'b0;
            ce_dec_q       <= 1'b0;
            ce_alu_q       <= 1'b0;
            ce_wb_q        <= 1'b0;
            pc_load_q      <= 1'b0;
            pc_inc_q       <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            halt_pending_q <= halt_pending_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
            ce_fetch_q     <= ce_fetch_d;
            ce_dec_q       <= ce_dec_d;
            ce_alu_q       <= ce_alu_d;
            ce_wb_q        <= ce_wb_d;
            pc_load_q      <= pc_load_d;
            pc_inc_q       <= pc_inc_d;
            halted_q       <= halted_d;
        end
    end

    // Next-state, timeout, error, halt-pending and retire-count logic.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        retire   = 1'b0;
        // A request arriving in the boundary cycle itself is honoured too.
        if (halt_pending_q || i_halt_req) begin
            boundary = S_HALT;
        end else if (i_run) begin
            boundary = S_FETCH;
        end else begin
            boundary = S_IDLE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_halt_req) begin
                    state_d = S_HALT;
                end else if (i_run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_fetch_ack) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_RESP;
            S_RESP: begin
                if (i_alu_branch) begin
                    retire  = 1'b1;
                    state_d = boundary;
                end else if (i_alu_ce_ram) begin
                    tmo_d   = '0;
                    state_d = S_MEM;
                end else if (i_alu_ce_reg) begin
                    state_d = S_WB;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_MEM: begin
                if (i_ram_ack) begin
                    state_d = S_WB;
                end else if (tmo_q == 8'(P_RAM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = boundary;
            end
            S_HALT: begin
                if (i_clr_err) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (i_resume && !err_q) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d = retire ? cnt_q + P_CNT_W'(1) : cnt_q;

        // Any entry into HALT satisfies an outstanding halt request.
        halt_pending_d = halt_pending_q | (i_halt_req && (state_q != S_HALT));
        if (state_d == S_HALT) begin
            halt_pending_d = 1'b0;
        end
    end

    // Pulse outputs: high for the first cycle spent in the issuing state.
    always_comb begin
        ce_fetch_d = (state_d == S_FETCH) && (state_q != S_FETCH);
        ce_dec_d   = (state_d == S_DECODE);
        ce_alu_d   = (state_d == S_EXEC);
        ce_wb_d    = (state_d == S_WB);
        pc_inc_d   = (state_d == S_WB);
        pc_load_d  = (state_q == S_RESP) && i_alu_branch;
        halted_d   = (state_d == S_HALT);
    end

    assign q_ce_fetch    = ce_fetch_q;
    assign q_ce_dec      = ce_dec_q;
    assign q_ce_alu      = ce_alu_q;
    assign q_ce_wb       = ce_wb_q;
    assign q_pc_load     = pc_load_q;
    assign q_pc_inc      = pc_inc_q;
    assign q_halted      = halted_q;
    assign q_err         = err_q;
    assign q_state       = state_q;
    assign q_instr_count = cnt_q;

endmodule

// File: tb/tb_prco_seq_ctrl.sv
// Testbench for prco_seq_ctrl: directed scenarios plus randomized stimulus,
// all checked against a behavioural model of the sequencing rules.
module tb_prco_seq_ctrl;

    localparam int TMO = 15;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 0, halt_req = 0, resume = 0, clr_err = 0;
    logic fetch_ack = 0, ram_ack = 0, alu_reg = 0, alu_ram = 0, alu_branch = 0;

    logic          ce_fetch, ce_dec, ce_alu, ce_wb, pc_load, pc_inc, halted, err;
    logic [2:0]    state;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    prco_seq_ctrl #(.P_RAM_TIMEOUT(TMO), .P_CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_halt_req(halt_req),
        .i_resume(resume), .i_clr_err(clr_err), .i_fetch_ack(fetch_ack),
        .i_ram_ack(ram_ack), .i_alu_ce_reg(alu_reg), .i_alu_ce_ram(alu_ram),
        .i_alu_branch(alu_branch), .q_ce_fetch(ce_fetch), .q_ce_dec(ce_dec),
        .q_ce_alu(ce_alu), .q_ce_wb(ce_wb), .q_pc_load(pc_load),
        .q_pc_inc(pc_inc), .q_halted(halted), .q_err(err), .q_state(state),
        .q_instr_count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase number (matches the visible state code),
    // error flag, pending halt, cycles waited in memory, retired count.
    int m_st, m_cnt, m_tmo;
    bit m_err, m_pend, m_fetch, m_load;

    task automatic model_step();
        int nxt;
        bit at_boundary;
        bit want_halt;
        nxt = m_st;
        m_load = 0;
        at_boundary = 0;
        want_halt = m_pend || halt_req;
        case (m_st)
            0: if (halt_req) nxt = 7; else if (run) nxt = 1;
            1: if (fetch_ack) nxt = 2;
            2: nxt = 3;
            3: nxt = 4;
            4: begin
                if (alu_branch) begin
                    m_load = 1; m_cnt = (m_cnt + 1) % (1 << CW); at_boundary = 1;
                end else if (alu_ram) begin
                    nxt = 5; m_tmo = 0;
                end else if (alu_reg) begin
                    nxt = 6;
                end else begin
                    m_err = 1; nxt = 7;
                end
            end
            5: begin
                if (ram_ack) nxt = 6;
                else begin
                    m_tmo++;
                    if (m_tmo >= TMO) begin m_err = 1; nxt = 7; end
                end
            end
            6: begin m_cnt = (m_cnt + 1) % (1 << CW); at_boundary = 1; end
            default: begin
                if (clr_err) begin m_err = 0; nxt = 0; end
                else if (resume && !m_err) nxt = 1;
            end
        endcase
        if (at_boundary) nxt = want_halt ? 7 : (run ? 1 : 0);
        if (halt_req && m_st != 7) m_pend = 1;
        if (nxt == 7) m_pend = 0;
        m_fetch = (nxt == 1) && (m_st != 1);
        m_st = nxt;
    endtask

    // Model advances on the same edges as the design.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_cnt = 0; m_tmo = 0;
            m_err = 0; m_pend = 0; m_fetch = 0; m_load = 0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("state",    int'(state),    m_st);
            check("ce_fetch", int'(ce_fetch), int'(m_fetch));
            check("ce_dec",   int'(ce_dec),   int'(m_st == 2));
            check("ce_alu",   int'(ce_alu),   int'(m_st == 3));
            check("ce_wb",    int'(ce_wb),    int'(m_st == 6));
            check("pc_inc",   int'(pc_inc),   int'(m_st == 6));
            check("pc_load",  int'(pc_load),  int'(m_load));
            check("halted",   int'(halted),   int'(m_st == 7));
            check("err",      int'(err),      int'(m_err));
            check("count",    int'(count),    m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n;
        n = 0;
        while (int'(state) != s && n < budget) begin
            cyc();
            n++;
        end
        check(name, int'(state), s);
    endtask

    int exp_st[6]  = '{1, 2, 3, 4, 6, 1};
    int exp_fe[6]  = '{1, 0, 0, 0, 0, 1};
    int exp_wb[6]  = '{0, 0, 0, 0, 1, 0};
    int exp_alu[6] = '{0, 0, 1, 0, 0, 0};

    initial begin
        int mem_cycles;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_pulses", int'({ce_fetch, ce_dec, ce_alu, ce_wb, pc_load, pc_inc}), 0);
        check("rst_flags", int'({halted, err}), 0);
        check("rst_count", int'(count), 0);

        // Back-to-back register ops: one retire every 5 cycles, counter wraps.
        run = 1; fetch_ack = 1; alu_reg = 1;
        for (int k = 1; k <= 81; k++) begin
            cyc();
            if (k <= 6) begin
                check("regop_state", int'(state), exp_st[k-1]);
                check("regop_fetch", int'(ce_fetch), exp_fe[k-1]);
                check("regop_wb", int'(ce_wb), exp_wb[k-1]);
                check("regop_alu", int'(ce_alu), exp_alu[k-1]);
            end
            if (k == 6)  check("regop_count1", int'(count), 1);
            if (k == 80) check("wrap_count15", int'(count), 15);
            if (k == 81) check("wrap_count0", int'(count), 0);
        end

        // RAM op without ack: times out after TMO memory cycles.
        alu_reg = 0; alu_ram = 1; ram_ack = 0;
        mem_cycles = 0;
        for (int i = 0; i < 60 && int'(state) != 7; i++) begin
            cyc();
            if (int'(state) == 5) mem_cycles++;
        end
        check("tmo_state", int'(state), 7);
        check("tmo_err", int'(err), 1);
        check("tmo_mem_cycles", mem_cycles, TMO);
        check("tmo_no_wb", int'(count), 0);

        // Resume ignored while in error; clear wins over resume.
        run = 0; alu_ram = 0;
        resume = 1;
        @(posedge clk); #1 resume = 0;
        @(negedge clk);
        check("resume_ignored", int'(state), 7);
        resume = 1; clr_err = 1;
        @(posedge clk); #1 resume = 0; clr_err = 0;
        @(negedge clk);
        check("clr_state", int'(state), 0);
        check("clr_err", int'(err), 0);

        // Async reset while waiting in MEM.
        run = 1; fetch_ack = 1; alu_ram = 1; ram_ack = 0;
        wait_state(5, 20, "reach_mem");
        #2 rst = 1;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_outs", int'({ce_fetch, ce_dec, ce_alu, ce_wb, pc_load, pc_inc, halted, err}), 0);
        run = 0; alu_ram = 0;
        @(posedge clk); #1 rst = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("arst_idle", int'(state), 0);
            check("arst_nopulse", int'(ce_fetch), 0);
        end

        // Halt request during DECODE: instruction completes, then HALT.
        run = 1; fetch_ack = 1; alu_reg = 1;
        wait_state(2, 20, "reach_decode");
        halt_req = 1;
        @(posedge clk); #1 halt_req = 0;
        wait_state(7, 20, "halt_reached");
        check("halt_flag", int'(halted), 1);
        check("halt_count", int'(count), 1);
        resume = 1;
        @(posedge clk); #1 resume = 0;
        @(negedge clk);
        check("resume_fetch", int'(state), 1);
        check("resume_pulse", int'(ce_fetch), 1);

        // Randomized traffic with occasional asynchronous resets.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1; #2 rst = 0;
            end
            run        = ($urandom_range(0, 9) < 7);
            halt_req   = ($urandom_range(0, 19) == 0);
            resume     = ($urandom_range(0, 4) == 0);
            clr_err    = ($urandom_range(0, 19) == 0);
            fetch_ack  = ($urandom_range(0, 1) == 1);
            ram_ack    = ($urandom_range(0, 99) < 15);
            alu_reg    = ($urandom_range(0, 9) < 4);
            alu_ram    = ($urandom_range(0, 9) < 4);
            alu_branch = ($urandom_range(0, 9) < 3);
        end
        @(posedge clk); #1;
        {run, halt_req, resume, clr_err, fetch_ack, ram_ack, alu_reg, alu_ram, alu_branch} = '0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
